// File: rtl/wb_ecc_pkg.sv
// Shared constants, health encoding and SECDED syndrome helper for the
// writeback ECC select path.
package wb_ecc_pkg;

  localparam int DATA_W = 32;
  localparam int CODE_W = 39;
  localparam int SYN_W  = 6;

  typedef enum logic [1:0] {
    HLTH_OK       = 2'd0,
    HLTH_DEGRADED = 2'd1,
    HLTH_FAILED   = 2'd2
  } health_e;

  // Mask of codeword positions (1..CODE_W-1) whose index has syndrome bit b set.
  function automatic logic [CODE_W-1:0] syn_mask(input int b);
    logic [CODE_W-1:0] m;
    m = '0;
    for (int p = 1; p < CODE_W; p++) begin
      m[p] = ((p >> b) & 1) != 0;
    end
    return m;
  endfunction

endpackage

// File: rtl/secded_dec_39_32.sv
// Combinational SECDED(39,32) decoder: syndrome, overall parity, single-bit
// correction and uncorrectable-error flag.
module secded_dec_39_32
  import wb_ecc_pkg::*;
(
  input  logic [CODE_W-1:0] code_in,
  output logic [DATA_W-1:0] data_out,
  output logic              ce,
  output logic              ue,
  output logic [SYN_W-1:0]  syn
);

  logic              par;
  logic [CODE_W-1:0] fixed;

  // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
  always_comb begin
    syn = '0;
    for (int b = 0; b < SYN_W; b++) begin
      syn[b] = ^(code_in & syn_mask(b));
    end
  end

  assign par = ^code_in;
  assign ce  = par && (syn <= SYN_W'(CODE_W - 1));
  assign ue  = (!par && (syn != '0)) || (par && (syn > SYN_W'(CODE_W - 1)));

  // syn == 0 with odd parity points at the overall parity bit, position 0.
  assign fixed = ce ? (code_in ^ (CODE_W'(1) << syn)) : code_in;

  // Data occupies the non-power-of-two positions in ascending order.
  assign data_out = {fixed[38:33], fixed[31:17], fixed[15:9], fixed[7:5], fixed[3]};

endmodule

// File: rtl/writeback_ecc_sel.sv
// Writeback result path: TMR-voted codeword select, single SECDED decode,
// registered corrected result, error counters and sticky health state.
module writeback_ecc_sel
  import wb_ecc_pkg::*;
#(
  parameter int NUM_SRC   = 3,
  parameter int SEL_W     = $clog2(NUM_SRC),
  parameter int CNT_W     = 8,
  parameter int CE_THRESH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      valid_in,
  input  logic [SEL_W-1:0]          sel,
  input  logic [NUM_SRC*CODE_W-1:0] code_in,
  input  logic                      err_clr,
  input  logic [2:0]                tmr_inj,
  output logic [DATA_W-1:0]         result,
  output logic                      valid_out,
  output logic                      ce_event,
  output logic                      ue_event,
  output logic                      mux_error,
  output logic [CNT_W-1:0]          ce_count,
  output logic [CNT_W-1:0]          ue_count,
  output logic [SEL_W-1:0]          last_err_src,
  output logic [1:0]                health
);

  logic [CODE_W-1:0] lane [3];
  logic [CODE_W-1:0] voted;
  logic              sel_ok;
  logic              lane_mismatch;

  logic [DATA_W-1:0] dec_data;
  logic              dec_ce;
  logic              dec_ue;
  logic [SYN_W-1:0]  dec_syn;

  logic              ce_hit;
  logic              ue_hit;
  logic [CNT_W-1:0]  ce_cnt_d;
  logic [CNT_W-1:0]  ue_cnt_d;
  logic [SEL_W-1:0]  last_src_d;
  health_e           state_q;
  health_e           state_d;

  assign sel_ok = 32'(sel) < NUM_SRC;

  // Three independent select lanes; tmr_inj[k] perturbs lane k for self-test.
  always_comb begin
    for (int k = 0; k < 3; k++) begin
      lane[k] = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
        if (32'(sel) == i) lane[k] = code_in[i*CODE_W +: CODE_W];
      end
      lane[k][0] = lane[k][0] ^ tmr_inj[k];
    end
  end

  assign voted         = (lane[0] & lane[1]) | (lane[0] & lane[2]) | (lane[1] & lane[2]);
  assign lane_mismatch = (lane[0] != lane[1]) || (lane[0] != lane[2]);

  secded_dec_39_32 u_dec (
    .code_in  (voted),
    .data_out (dec_data),
    .ce       (dec_ce),
    .ue       (dec_ue),
    .syn      (dec_syn)
  );

  // An out-of-range select never raises an ECC event.
  assign ce_hit = valid_in && sel_ok && dec_ce && (dec_syn <= SYN_W'(CODE_W - 1));
  assign ue_hit = valid_in && sel_ok && dec_ue;

  always_comb begin
    ce_cnt_d   = ce_count;
    ue_cnt_d   = ue_count;
    last_src_d = last_err_src;
    if (err_clr) begin
      ce_cnt_d   = '0;
      ue_cnt_d   = '0;
      last_src_d = '0;
    end else begin
      if (ce_hit && (ce_count != '1)) ce_cnt_d = ce_count + 1'b1;
      if (ue_hit && (ue_count != '1)) ue_cnt_d = ue_count + 1'b1;
      if (ce_hit || ue_hit)           last_src_d = sel;
    end
  end

  always_comb begin
    state_d = state_q;
    if (err_clr) begin
      state_d = HLTH_OK;
    end else begin
      case (state_q)
        HLTH_OK: begin
          if (ue_hit)                              state_d = HLTH_FAILED;
          else if (ce_cnt_d >= CNT_W'(CE_THRESH))  state_d = HLTH_DEGRADED;
        end
        HLTH_DEGRADED: if (ue_hit) state_d = HLTH_FAILED;
        HLTH_FAILED:   state_d = HLTH_FAILED;
        default:       state_d = HLTH_OK;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      result       <= '0;
      valid_out    <= 1'b0;
      ce_event     <= 1'b0;
      ue_event     <= 1'b0;
      mux_error    <= 1'b0;
      ce_count     <= '0;
      ue_count     <= '0;
      last_err_src <= '0;
      state_q      <= HLTH_OK;
    end else begin
      valid_out    <= valid_in;
      ce_event     <= ce_hit;
      ue_event     <= ue_hit;
      mux_error    <= valid_in && (!sel_ok || lane_mismatch);
      if (valid_in) result <= sel_ok ? dec_data : '0;
      ce_count     <= ce_cnt_d;
      ue_count     <= ue_cnt_d;
      last_err_src <= last_src_d;
      state_q      <= state_d;
    end
  end

  assign health = state_q;

endmodule

// File: tb/tb_writeback_ecc_sel.sv
// Scoreboard bench for writeback_ecc_sel: stimulus pushes reference-model
// expectations, a monitor pops and compares whenever valid_out is seen.
module tb_writeback_ecc_sel;

  localparam int NUM_SRC   = 3;
  localparam int SEL_W     = 2;
  localparam int CNT_W     = 8;
  localparam int CE_THRESH = 4;
  localparam int CODE_W    = 39;
  localparam int CNT_MAX   = (1 << CNT_W) - 1;

  logic                      clk = 1'b0;
  logic                      rst = 1'b0;
  logic                      valid_in = 1'b0;
  logic [SEL_W-1:0]          sel = '0;
  logic [NUM_SRC*CODE_W-1:0] code_in = '0;
  logic                      err_clr = 1'b0;
  logic [2:0]                tmr_inj = '0;
  logic [31:0]               result;
  logic                      valid_out;
  logic                      ce_event;
  logic                      ue_event;
  logic                      mux_error;
  logic [CNT_W-1:0]          ce_count;
  logic [CNT_W-1:0]          ue_count;
  logic [SEL_W-1:0]          last_err_src;
  logic [1:0]                health;

  always #5 clk = ~clk;

  writeback_ecc_sel #(
    .NUM_SRC(NUM_SRC), .SEL_W(SEL_W), .CNT_W(CNT_W), .CE_THRESH(CE_THRESH)
  ) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .sel(sel), .code_in(code_in),
    .err_clr(err_clr), .tmr_inj(tmr_inj), .result(result), .valid_out(valid_out),
    .ce_event(ce_event), .ue_event(ue_event), .mux_error(mux_error),
    .ce_count(ce_count), .ue_count(ue_count), .last_err_src(last_err_src),
    .health(health)
  );

  typedef struct {
    logic [31:0] result;
    logic        ce;
    logic        ue;
    logic        mux;
    int          ce_cnt;
    int          ue_cnt;
    int          last;
    int          health;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   m_ce = 0, m_ue = 0, m_last = 0, m_health = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, wanted 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [38:0] encode(input logic [31:0] d);
    logic [38:0] c;
    int k, s;
    c = '0; k = 0; s = 0;
    for (int p = 1; p < 39; p++) if ((p & (p - 1)) != 0) begin c[p] = d[k]; k++; end
    for (int p = 1; p < 39; p++) if (c[p]) s = s ^ p;
    for (int b = 0; b < 6; b++) c[1 << b] = s[b];
    c[0] = ^c[38:1];
    return c;
  endfunction

  function automatic void ref_decode(input logic [38:0] c, output logic [31:0] d,
                                     output logic ce, output logic ue);
    int syn, ones, k;
    syn = 0; ones = 0; k = 0; ce = 1'b0; ue = 1'b0;
    for (int p = 0; p < 39; p++) if (c[p]) begin ones++; syn = syn ^ p; end
    if (ones % 2 == 1) begin
      if (syn <= 38) begin ce = 1'b1; c[syn] = ~c[syn]; end
      else ue = 1'b1;
    end else if (syn != 0) begin
      ue = 1'b1;
    end
    d = '0;
    for (int p = 1; p < 39; p++) if ((p & (p - 1)) != 0) begin d[k] = c[p]; k++; end
  endfunction

  function automatic logic [NUM_SRC*CODE_W-1:0] pack3(input logic [38:0] c0, c1, c2);
    return {c2, c1, c0};
  endfunction

  function automatic logic [38:0] rand_code();
    logic [38:0] c;
    int r, b1, b2;
    c = encode($urandom);
    r = $urandom_range(0, 99);
    b1 = $urandom_range(0, 38);
    b2 = (b1 + $urandom_range(1, 38)) % 39;
    if (r < 25)      c = c ^ (39'd1 << b1);
    else if (r < 40) c = c ^ (39'd1 << b1) ^ (39'd1 << b2);
    return c;
  endfunction

  // Apply one cycle of inputs at the falling edge and record what must come out.
  task automatic issue(input logic v, input int s, input logic [NUM_SRC*CODE_W-1:0] cw,
                       input logic clr, input logic [2:0] inj);
    exp_t        e;
    logic [38:0] c;
    logic [31:0] d;
    logic        ce, ue, sel_ok;
    @(negedge clk);
    valid_in = v; sel = SEL_W'(s); code_in = cw; err_clr = clr; tmr_inj = inj;
    sel_ok = s < NUM_SRC;
    d = '0; ce = 1'b0; ue = 1'b0;
    if (v && sel_ok) begin
      c = cw[s*CODE_W +: CODE_W];
      if ($countones(inj) >= 2) c[0] = ~c[0];
      ref_decode(c, d, ce, ue);
    end
    if (clr) begin
      m_ce = 0; m_ue = 0; m_last = 0; m_health = 0;
    end else if (v) begin
      if (ce && m_ce < CNT_MAX) m_ce++;
      if (ue && m_ue < CNT_MAX) m_ue++;
      if (ce || ue) m_last = s;
      if (ue) m_health = 2;
      else if (m_health == 0 && m_ce >= CE_THRESH) m_health = 1;
    end
    if (v) begin
      e.result = d; e.ce = ce; e.ue = ue;
      e.mux = !sel_ok || (inj != 3'b000 && inj != 3'b111);
      e.ce_cnt = m_ce; e.ue_cnt = m_ue; e.last = m_last; e.health = m_health;
      sb.push_back(e);
    end
  endtask

  task automatic idle();
    issue(1'b0, 0, '0, 1'b0, 3'b000);
  endtask

  // Monitor: compares every delivered result against the queued expectation.
  initial begin
    exp_t        e;
    logic [31:0] last_res;
    last_res = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst) begin
        last_res = '0;
      end else if (valid_out) begin
        if (sb.size() == 0) begin
          check("unexpected_valid_out", 64'(valid_out), 64'd0);
        end else begin
          e = sb.pop_front();
          check("sb_result",   64'(result),       64'(e.result));
          check("sb_ce_event", 64'(ce_event),     64'(e.ce));
          check("sb_ue_event", 64'(ue_event),     64'(e.ue));
          check("sb_mux_err",  64'(mux_error),    64'(e.mux));
          check("sb_ce_count", 64'(ce_count),     64'(e.ce_cnt));
          check("sb_ue_count", 64'(ue_count),     64'(e.ue_cnt));
          check("sb_last_src", 64'(last_err_src), 64'(e.last));
          check("sb_health",   64'(health),       64'(e.health));
          last_res = e.result;
        end
      end else begin
        check("idle_hold_result", 64'(result), 64'(last_res));
        check("idle_pulses", 64'({ce_event, ue_event, mux_error}), 64'd0);
      end
    end
  end

  initial begin
    logic [38:0] c_ce, c_ue;

    // 1: reset
    repeat (3) @(negedge clk);
    check("rst_outputs", {result, valid_out, ce_event, ue_event, mux_error,
                          ce_count, ue_count, last_err_src, health}, 64'd0);
    rst = 1'b1;
    @(negedge clk);
    check("post_rst_outputs", {result, valid_out, ce_event, ue_event, mux_error,
                               ce_count, ue_count, last_err_src, health}, 64'd0);

    // 2: clean path
    issue(1'b1, 1, pack3('0, encode(32'hDEADBEEF), '0), 1'b0, 3'b000);
    @(posedge clk); #1;
    check("clean_result", 64'(result), 64'hDEADBEEF);
    check("clean_flags", 64'({valid_out, ce_event, ue_event, mux_error}), 64'b1000);

    // 3: correctable errors up to the degrade threshold
    c_ce = encode(32'h12345678) ^ (39'd1 << 7);
    for (int i = 0; i < 4; i++) begin
      issue(1'b1, 0, pack3(c_ce, '0, '0), 1'b0, 3'b000);
      @(posedge clk); #1;
      check("ce_result", 64'(result), 64'h12345678);
      check("ce_event", 64'(ce_event), 64'd1);
      check("ce_count", 64'(ce_count), 64'(i + 1));
    end
    check("ce_degraded", 64'(health), 64'd1);

    // 4: uncorrectable error, then clear
    c_ue = encode(32'hCAFEF00D) ^ (39'd1 << 3) ^ (39'd1 << 9);
    issue(1'b1, 2, pack3('0, '0, c_ue), 1'b0, 3'b000);
    @(posedge clk); #1;
    check("ue_status", 64'({ue_event, ue_count, last_err_src, health}),
          64'({1'b1, 8'd1, 2'd2, 2'd2}));
    issue(1'b0, 0, '0, 1'b1, 3'b000);
    @(posedge clk); #1;
    check("clr_status", 64'({ce_count, ue_count, health}), 64'd0);

    // 5: TMR lane fault and out-of-range select
    issue(1'b1, 1, pack3('0, encode(32'hA5A5_0F0F), '0), 1'b0, 3'b010);
    @(posedge clk); #1;
    check("tmr_result", 64'(result), 64'hA5A50F0F);
    check("tmr_mux_err", 64'(mux_error), 64'd1);
    issue(1'b1, 3, pack3(c_ce, c_ce, c_ue), 1'b0, 3'b000);
    @(posedge clk); #1;
    check("oor_result", 64'({result, mux_error, ce_event, ue_event}), 64'({32'd0, 3'b100}));

    // 6: saturation, clear collision, reset mid-stream
    for (int i = 0; i < 300; i++) issue(1'b1, 0, pack3(c_ce, '0, '0), 1'b0, 3'b000);
    @(posedge clk); #1;
    check("ce_saturated", 64'(ce_count), 64'(CNT_MAX));
    issue(1'b1, 0, pack3(c_ce, '0, '0), 1'b1, 3'b000);
    @(posedge clk); #1;
    check("clr_collision", 64'({ce_event, ce_count}), 64'({1'b1, 8'd0}));

    for (int i = 0; i < 400; i++)
      issue($urandom_range(0, 3) != 0, $urandom_range(0, 3),
            pack3(rand_code(), rand_code(), rand_code()),
            $urandom_range(0, 15) == 0,
            ($urandom_range(0, 7) == 0) ? 3'($urandom) : 3'b000);

    issue(1'b1, 1, pack3('0, encode(32'h0BAD_CAFE), '0), 1'b0, 3'b000);
    issue(1'b1, 0, pack3(encode(32'h1111_2222), '0, '0), 1'b0, 3'b000);
    #2 rst = 1'b0;
    sb.delete();
    m_ce = 0; m_ue = 0; m_last = 0; m_health = 0;
    #1;
    check("midstream_rst_valid", 64'(valid_out), 64'd0);
    valid_in = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 100; i++)
      issue($urandom_range(0, 3) != 0, $urandom_range(0, 3),
            pack3(rand_code(), rand_code(), rand_code()),
            $urandom_range(0, 15) == 0,
            ($urandom_range(0, 7) == 0) ? 3'($urandom) : 3'b000);

    repeat (3) idle();
    check("scoreboard_drain", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
